// File: rtl/bt656cap_bufsched.sv
// rtl/bt656cap_bufsched.sv - BT.656 capture frame-buffer scheduler: free/done address queues, per-frame buffer hand-off, CSR bank
module bt656cap_bufsched #(
    parameter logic [3:0] csr_addr  = 4'h0,
    parameter int         fml_depth = 27
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [13:0]          csr_a,
    input  logic                 csr_we,
    input  logic [31:0]          csr_di,
    output logic [31:0]          csr_do,
    output logic                 irq,
    input  logic                 start_of_frame,
    input  logic                 in_frame,
    output logic [fml_depth-6:0] fml_adr_base,
    output logic                 frame_drop
);
    localparam int AW = fml_depth - 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        CAPTURE  = 2'd2,
        DROP     = 2'd3
    } state_t;

    state_t state;

    logic        enable;
    logic        ovf;
    logic [15:0] drop_count;
    logic        in_frame_r;
    logic        fe;

    logic          csr_sel, csr_wr;
    logic          wr0, wr1, wr2, wr3;
    logic          flush;

    logic [AW-1:0] free_mem [0:3];
    logic [1:0]    free_rd, free_wr, free_wr1;
    logic [2:0]    free_count;
    logic [AW-1:0] free_head;

    logic [AW-1:0] done_mem [0:3];
    logic [1:0]    done_rd, done_wr, done_widx;
    logic [2:0]    done_count;
    logic [AW-1:0] done_head;

    logic       sof_take, sof_drop, cap_end;
    logic       done_pop, done_full, done_push, recycle;
    logic [2:0] free_avail;
    logic       free_push0, free_push1;
    logic       ovf_set, drop_inc;

    logic unused_bits;
    assign unused_bits = ^{csr_a[9:2], csr_di[31:fml_depth], csr_di[4:3]};

    assign csr_sel = (csr_a[13:10] == csr_addr);
    assign csr_wr  = csr_sel & csr_we;
    assign wr0     = csr_wr & (csr_a[1:0] == 2'd0);
    assign wr1     = csr_wr & (csr_a[1:0] == 2'd1);
    assign wr2     = csr_wr & (csr_a[1:0] == 2'd2);
    assign wr3     = csr_wr & (csr_a[1:0] == 2'd3);
    assign flush   = wr0 & csr_di[1];

    assign fe        = in_frame_r & ~in_frame;
    assign free_head = free_mem[free_rd];
    assign done_head = done_mem[done_rd];

    // Queue arbitration: the recycled buffer claims free space before a CSR push.
    always_comb begin
        sof_take   = (state == WAIT_SOF) && enable && start_of_frame && (free_count != 3'd0);
        sof_drop   = (state == WAIT_SOF) && enable && start_of_frame && (free_count == 3'd0);
        cap_end    = (state == CAPTURE) && fe;
        done_pop   = wr2 && (done_count != 3'd0);
        done_full  = (done_count == 3'd4) && !done_pop;
        done_push  = cap_end && (flush || !done_full);
        recycle    = cap_end && !flush && done_full;
        free_avail = 3'd4 - free_count + {2'b0, sof_take};
        free_push0 = recycle && (free_avail != 3'd0);
        free_push1 = wr1 && (free_avail > {2'b0, free_push0});
        ovf_set    = (recycle && (free_avail == 3'd0)) || (wr1 && !free_push1);
        drop_inc   = sof_drop || recycle;
        free_wr1   = free_wr + {1'b0, free_push0};
        done_widx  = flush ? 2'd0 : done_wr;
    end

    always_ff @(posedge sys_clk) begin
        if (free_push0)
            free_mem[free_wr] <= fml_adr_base;
        if (free_push1)
            free_mem[free_wr1] <= csr_di[fml_depth-1:5];
        if (done_push)
            done_mem[done_widx] <= fml_adr_base;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            free_rd    <= 2'd0;
            free_wr    <= 2'd0;
            free_count <= 3'd0;
            done_rd    <= 2'd0;
            done_wr    <= 2'd0;
            done_count <= 3'd0;
        end else begin
            if (flush) begin
                free_rd    <= 2'd0;
                free_wr    <= 2'd0;
                free_count <= 3'd0;
            end else begin
                free_rd    <= free_rd + {1'b0, sof_take};
                free_wr    <= free_wr + {1'b0, free_push0} + {1'b0, free_push1};
                free_count <= free_count + {2'b0, free_push0} + {2'b0, free_push1}
                              - {2'b0, sof_take};
            end
            // A frame-end push coinciding with a flush lands in the freshly cleared queue.
            if (flush) begin
                done_rd    <= 2'd0;
                done_wr    <= {1'b0, done_push};
                done_count <= {2'b0, done_push};
            end else begin
                done_rd    <= done_rd + {1'b0, done_pop};
                done_wr    <= done_wr + {1'b0, done_push};
                done_count <= done_count + {2'b0, done_push} - {2'b0, done_pop};
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            enable     <= 1'b0;
            ovf        <= 1'b0;
            drop_count <= 16'd0;
            irq        <= 1'b0;
            in_frame_r <= 1'b0;
            csr_do     <= 32'd0;
        end else begin
            in_frame_r <= in_frame;
            irq        <= (done_count != 3'd0);
            if (wr0)
                enable <= csr_di[0];
            if (ovf_set)
                ovf <= 1'b1;
            else if (wr0 && csr_di[2])
                ovf <= 1'b0;
            if (wr3)
                drop_count <= 16'd0;
            else if (drop_inc && (drop_count != 16'hFFFF))
                drop_count <= drop_count + 16'd1;
            if (!csr_sel) begin
                csr_do <= 32'd0;
            end else begin
                case (csr_a[1:0])
                    2'd0: csr_do <= {18'd0, state, 1'b0, done_count, 1'b0, free_count,
                                     2'b00, ovf, enable};
                    2'd1: csr_do <= (done_count != 3'd0)
                                    ? {{(32-fml_depth){1'b0}}, done_head, 5'd0} : 32'd0;
                    2'd2: csr_do <= 32'd0;
                    default: csr_do <= {16'd0, drop_count};
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= IDLE;
            fml_adr_base <= '0;
            frame_drop   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    frame_drop <= 1'b1;
                    if (enable)
                        state <= WAIT_SOF;
                end
                WAIT_SOF: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (sof_take) begin
                        fml_adr_base <= free_head;
                        frame_drop   <= 1'b0;
                        state        <= CAPTURE;
                    end else if (sof_drop) begin
                        frame_drop <= 1'b1;
                        state      <= DROP;
                    end
                end
                // A repeated start_of_frame keeps the same buffer; enable is not checked mid-frame.
                CAPTURE: begin
                    if (fe) begin
                        frame_drop <= 1'b1;
                        state      <= WAIT_SOF;
                    end
                end
                default: begin
                    if (fe)
                        state <= WAIT_SOF;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bt656cap_bufsched.sv
// tb/tb_bt656cap_bufsched.sv - directed self-checking bench for bt656cap_bufsched
module tb_bt656cap_bufsched;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [13:0] csr_a = 14'd0;
    logic        csr_we = 1'b0;
    logic [31:0] csr_di = 32'd0;
    logic [31:0] csr_do;
    logic        irq;
    logic        start_of_frame = 1'b0;
    logic        in_frame = 1'b0;
    logic [21:0] fml_adr_base;
    logic        frame_drop;

    int n_cmp = 0;
    int n_fail = 0;

    bt656cap_bufsched #(.csr_addr(4'h0), .fml_depth(27)) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .csr_a          (csr_a),
        .csr_we         (csr_we),
        .csr_di         (csr_di),
        .csr_do         (csr_do),
        .irq            (irq),
        .start_of_frame (start_of_frame),
        .in_frame       (in_frame),
        .fml_adr_base   (fml_adr_base),
        .frame_drop     (frame_drop)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic csr_write(input logic [1:0] r, input logic [31:0] d);
        @(negedge sys_clk);
        csr_a  = {12'd0, r};
        csr_we = 1'b1;
        csr_di = d;
        @(negedge sys_clk);
        csr_we = 1'b0;
        csr_di = 32'd0;
    endtask

    task automatic csr_read(input logic [1:0] r, output logic [31:0] d);
        @(negedge sys_clk);
        csr_a  = {12'd0, r};
        csr_we = 1'b0;
        @(negedge sys_clk);
        d = csr_do;
    endtask

    task automatic pulse_sof();
        @(negedge sys_clk);
        start_of_frame = 1'b1;
        in_frame       = 1'b1;
        @(negedge sys_clk);
        start_of_frame = 1'b0;
    endtask

    task automatic end_frame();
        @(negedge sys_clk);
        in_frame = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        #2 sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        n_cmp++; if (csr_do !== 32'd0) begin n_fail++; $display("FAIL rst_csr_do got %h want %h", csr_do, 32'd0); end
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq got %b want 0", irq); end
        n_cmp++; if (fml_adr_base !== 22'd0) begin n_fail++; $display("FAIL rst_base got %h want 0", fml_adr_base); end
        n_cmp++; if (frame_drop !== 1'b1) begin n_fail++; $display("FAIL rst_drop got %b want 1", frame_drop); end
        sys_rst = 1'b0;
        csr_read(2'd0, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_reg0 got %h want %h", d, 32'h0); end
        csr_read(2'd3, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_reg3 got %h want %h", d, 32'h0); end
    endtask

    task automatic test_capture();
        logic [31:0] d;
        csr_write(2'd0, 32'h1);
        csr_write(2'd1, 32'h0010_0000);
        csr_write(2'd1, 32'h0020_0000);
        csr_read(2'd0, d);
        n_cmp++; if (d !== 32'h1021) begin n_fail++; $display("FAIL cap_status0 got %h want %h", d, 32'h1021); end
        pulse_sof();
        n_cmp++; if (fml_adr_base !== 22'h8000) begin n_fail++; $display("FAIL cap_base got %h want %h", fml_adr_base, 22'h8000); end
        n_cmp++; if (frame_drop !== 1'b0) begin n_fail++; $display("FAIL cap_drop got %b want 0", frame_drop); end
        csr_read(2'd0, d);
        n_cmp++; if (d !== 32'h2011) begin n_fail++; $display("FAIL cap_status1 got %h want %h", d, 32'h2011); end
    endtask

    task automatic test_irq_retire();
        logic [31:0] d;
        end_frame();
        n_cmp++; if (frame_drop !== 1'b1) begin n_fail++; $display("FAIL fe_drop got %b want 1", frame_drop); end
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_lag got %b want 0", irq); end
        @(negedge sys_clk);
        n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set got %b want 1", irq); end
        csr_read(2'd0, d);
        n_cmp++; if (d !== 32'h1111) begin n_fail++; $display("FAIL fe_status got %h want %h", d, 32'h1111); end
        csr_read(2'd1, d);
        n_cmp++; if (d !== 32'h0010_0000) begin n_fail++; $display("FAIL done_head got %h want %h", d, 32'h0010_0000); end
        csr_write(2'd2, 32'h0);
        @(negedge sys_clk);
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %b want 0", irq); end
    endtask

    task automatic test_drop();
        logic [31:0] d;
        pulse_sof();
        n_cmp++; if (fml_adr_base !== 22'h10000) begin n_fail++; $display("FAIL drop_prebase got %h want %h", fml_adr_base, 22'h10000); end
        end_frame();
        csr_write(2'd2, 32'h0);
        pulse_sof();
        n_cmp++; if (frame_drop !== 1'b1) begin n_fail++; $display("FAIL drop_flag got %b want 1", frame_drop); end
        csr_read(2'd0, d);
        n_cmp++; if (d !== 32'h3001) begin n_fail++; $display("FAIL drop_state got %h want %h", d, 32'h3001); end
        csr_read(2'd3, d);
        n_cmp++; if (d !== 32'd1) begin n_fail++; $display("FAIL drop_cnt1 got %h want %h", d, 32'd1); end
        end_frame();
        for (int i = 0; i < 5; i++) begin
            pulse_sof();
            end_frame();
        end
        csr_read(2'd3, d);
        n_cmp++; if (d !== 32'd6) begin n_fail++; $display("FAIL drop_cnt6 got %h want %h", d, 32'd6); end
        csr_read(2'd0, d);
        n_cmp++; if (d !== 32'h1001) begin n_fail++; $display("FAIL drop_back got %h want %h", d, 32'h1001); end
    endtask

    task automatic test_ovf();
        logic [31:0] d;
        for (int i = 0; i < 5; i++)
            csr_write(2'd1, 32'h0040_0000 + 32'(i) * 32'h20);
        csr_read(2'd0, d);
        n_cmp++; if (d !== 32'h1043) begin n_fail++; $display("FAIL ovf_set got %h want %h", d, 32'h1043); end
        csr_write(2'd0, 32'h5);
        csr_read(2'd0, d);
        n_cmp++; if (d !== 32'h1041) begin n_fail++; $display("FAIL ovf_clr got %h want %h", d, 32'h1041); end
    endtask

    task automatic test_done_full();
        logic [31:0] d;
        logic [21:0] exp_base;
        for (int i = 0; i < 4; i++) begin
            pulse_sof();
            exp_base = 22'h20000 + 22'(i);
            n_cmp++; if (fml_adr_base !== exp_base) begin n_fail++; $display("FAIL fill_base%0d got %h want %h", i, fml_adr_base, exp_base); end
            end_frame();
        end
        csr_read(2'd0, d);
        n_cmp++; if (d !== 32'h1401) begin n_fail++; $display("FAIL fill_status got %h want %h", d, 32'h1401); end
        for (int i = 0; i < 4; i++)
            csr_write(2'd1, 32'h0050_0000 + 32'(i) * 32'h20);
        pulse_sof();
        n_cmp++; if (fml_adr_base !== 22'h28000) begin n_fail++; $display("FAIL rcy_base got %h want %h", fml_adr_base, 22'h28000); end
        end_frame();
        csr_read(2'd0, d);
        n_cmp++; if (d !== 32'h1441) begin n_fail++; $display("FAIL rcy_status got %h want %h", d, 32'h1441); end
        csr_read(2'd3, d);
        n_cmp++; if (d !== 32'd7) begin n_fail++; $display("FAIL rcy_cnt got %h want %h", d, 32'd7); end
        csr_read(2'd1, d);
        n_cmp++; if (d !== 32'h0040_0000) begin n_fail++; $display("FAIL rcy_head got %h want %h", d, 32'h0040_0000); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        csr_write(2'd0, 32'h3);
        csr_read(2'd0, d);
        n_cmp++; if (d !== 32'h1001) begin n_fail++; $display("FAIL flush_idle got %h want %h", d, 32'h1001); end
        csr_write(2'd1, 32'h0060_0000);
        csr_write(2'd1, 32'h0060_0020);
        @(negedge sys_clk);
        csr_a          = 14'd1;
        csr_we         = 1'b1;
        csr_di         = 32'h0060_0040;
        start_of_frame = 1'b1;
        in_frame       = 1'b1;
        @(negedge sys_clk);
        csr_we         = 1'b0;
        csr_di         = 32'd0;
        start_of_frame = 1'b0;
        n_cmp++; if (fml_adr_base !== 22'h30000) begin n_fail++; $display("FAIL b2b_base got %h want %h", fml_adr_base, 22'h30000); end
        csr_read(2'd0, d);
        n_cmp++; if (d !== 32'h2021) begin n_fail++; $display("FAIL b2b_status got %h want %h", d, 32'h2021); end
        pulse_sof();
        n_cmp++; if (fml_adr_base !== 22'h30000) begin n_fail++; $display("FAIL restart_base got %h want %h", fml_adr_base, 22'h30000); end
        csr_read(2'd0, d);
        n_cmp++; if (d !== 32'h2021) begin n_fail++; $display("FAIL restart_status got %h want %h", d, 32'h2021); end
        csr_write(2'd0, 32'h3);
        csr_read(2'd0, d);
        n_cmp++; if (d !== 32'h2001) begin n_fail++; $display("FAIL flush_cap got %h want %h", d, 32'h2001); end
        end_frame();
        csr_read(2'd0, d);
        n_cmp++; if (d !== 32'h1101) begin n_fail++; $display("FAIL flush_land got %h want %h", d, 32'h1101); end
        csr_read(2'd1, d);
        n_cmp++; if (d !== 32'h0060_0000) begin n_fail++; $display("FAIL flush_head got %h want %h", d, 32'h0060_0000); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        csr_write(2'd1, 32'h0070_0000);
        pulse_sof();
        n_cmp++; if (frame_drop !== 1'b0) begin n_fail++; $display("FAIL mid_capture got %b want 0", frame_drop); end
        @(negedge sys_clk);
        sys_rst = 1'b1;
        #1;
        n_cmp++; if (fml_adr_base !== 22'd0) begin n_fail++; $display("FAIL mid_base got %h want 0", fml_adr_base); end
        n_cmp++; if (frame_drop !== 1'b1) begin n_fail++; $display("FAIL mid_drop got %b want 1", frame_drop); end
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_irq got %b want 0", irq); end
        n_cmp++; if (csr_do !== 32'd0) begin n_fail++; $display("FAIL mid_csr_do got %h want 0", csr_do); end
        @(negedge sys_clk);
        sys_rst  = 1'b0;
        in_frame = 1'b0;
        csr_read(2'd0, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_status got %h want %h", d, 32'h0); end
        csr_read(2'd3, d);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_cnt got %h want %h", d, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_irq_retire();
        test_drop();
        test_ovf();
        test_done_full();
        test_back_to_back();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/bt656cap_bufsched.md
Name: bt656cap_bufsched

Overview:
- Frame-buffer scheduler for the BT.656 capture path.
- Software queues up to 4 free frame-buffer addresses through CSRs.
- On each start of frame, the block hands the next free buffer to the DMA datapath via fml_adr_base, or tells the datapath to drop the frame when no buffer is free.
- On frame end it moves the filled buffer to a done queue and raises irq until software retires it.

Parameters:
- csr_addr, 4'h0, CSR bank select, compared with csr_a[13:10]
- fml_depth, 27, FML address width; buffers are 32-byte aligned

Ports:
- sys_clk  in  1  system clock; the only clock
- sys_rst  in  1  reset, asynchronous, active-high
- csr_a  in  14  CSR address
- csr_we  in  1  CSR write strobe
- csr_di  in  32  CSR write data
- csr_do  out  32  CSR read data, registered
- irq  out  1  level interrupt: done queue not empty
- start_of_frame  in  1  one-cycle pulse from capture datapath
- in_frame  in  1  high while datapath is capturing active video
- fml_adr_base  out  fml_depth-5  base address of current buffer (address bits fml_depth-1:5)
- frame_drop  out  1  1 = datapath must not issue bursts for this frame

Behaviour:
- Reset (async) values: csr_do=0, irq=0, fml_adr_base=0, frame_drop=1, state=IDLE, both queues empty, drop_count=0, ovf=0, enable=0.
- CSR decode:
  - The bank is selected when csr_a[13:10]==csr_addr; registers are decoded on csr_a[1:0].
  - Reads have 1-cycle latency; csr_do=0 when the bank is not selected.
  - Reg 0 read: bit0 enable, bit1 ovf, bits6:4 free_count, bits10:8 done_count, bits13:12 state (IDLE=0, WAIT_SOF=1, CAPTURE=2, DROP=3).
  - Reg 0 write: bit0 sets enable; bit1=1 flushes both queues; bit2=1 clears ovf.
  - Reg 1 write: pushes csr_di[fml_depth-1:5] into the free queue. If the free queue is full, the write is ignored and ovf is set.
  - Reg 1 read: {done head, 5'd0}, or 0 if the done queue is empty.
  - Reg 2 write (any data): pops the done queue; ignored if the done queue is empty. Reg 2 read returns 0.
  - Reg 3 read: drop_count[15:0]. Reg 3 write clears drop_count.
- Queues: free and done are each a 4-entry FIFO with a 3-bit count (0..4).
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
- irq is registered: irq = (done_count != 0) on the next cycle.
- fe (frame end) = in_frame_r & ~in_frame, where in_frame_r is a 1-cycle delayed copy of in_frame.
- FSM:
  - IDLE: frame_drop=1. Goes to WAIT_SOF when enable=1.
  - WAIT_SOF: if enable=0, go to IDLE. On start_of_frame:
    - free_count>0: pop the free head into fml_adr_base, frame_drop<=0, go to CAPTURE.
    - free_count==0: frame_drop<=1, drop_count++ (saturating at 16'hFFFF), go to DROP.
  - CAPTURE:
    - On fe: push fml_adr_base into the done queue, frame_drop<=1, go to WAIT_SOF.
    - start_of_frame without fe restarts the same buffer: no pop, no push, state unchanged.
    - Clearing enable mid-frame does not abort; the frame completes normally.
  - DROP: on fe, go to WAIT_SOF. start_of_frame is ignored.
- Done queue full at fe: the filled buffer is recycled to the free queue tail and drop_count++. If the free queue is also full, the buffer is discarded and ovf<=1.
- fml_adr_base and frame_drop are valid 1 cycle after start_of_frame. The datapath never issues its first burst within 2 cycles of start_of_frame.
- Flush:
  - Free queue: an SOF pop in the same cycle still takes the head; the queue ends empty.
  - Done queue: an fe push in the same cycle lands after the clear (done_count=1).
  - The in-flight CAPTURE buffer is unaffected.
- fe and start_of_frame in the same cycle: fe is processed and the FSM goes to WAIT_SOF; that start_of_frame is not acted on.
- Asserting reset mid-frame returns everything to reset values; all queued addresses are lost.

Test Plan:
- Reset, write reg0=1, push 0x100000 and 0x200000, pulse SOF -> fml_adr_base=0x8000 (0x100000>>5), frame_drop=0 one cycle later, free_count=1.
- Drop in_frame after a frame -> done_count=1, irq=1 next cycle; reg1 reads 0x100000; write reg2 -> irq=0.
- Free queue empty, pulse SOF -> frame_drop=1, state=DROP, reg3 reads 1; 5 more such frames -> reg3=6.
- Push 5 addresses -> free_count=4, ovf=1; write reg0=5 -> ovf=0, enable still 1.
- Fill done queue to 4, complete a frame with free_count=3 -> buffer returned to free tail (free_count=4), drop_count+1, done_count=4.
- Same-cycle push to free queue and SOF pop with free_count=2 -> free_count=2. Flush during CAPTURE -> both counts 0; the capture buffer still lands in done at frame end.
